// File: rtl/lock_key_loader_pkg.sv
// Shared constants and state encoding for the key loader and its accumulator.
package lock_key_pkg;

    localparam int KEY_W  = 104;
    localparam int NBYTES = KEY_W / 8;
    localparam int CNT_W  = $clog2(NBYTES + 1);
    localparam int IDX_W  = $clog2(KEY_W);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_e;

endpackage

// File: rtl/lock_key_loader_if.sv
// Byte-stream handshake from the secure key store into the loader.
interface lock_key_loader_if;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);

endinterface

// File: rtl/lock_key_loader_chk_acc.sv
// Running XOR of the key bytes with a compare against the received checksum.
module key_chk_acc (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    input  logic [7:0] cmp_byte,
    output logic [7:0] acc,
    output logic       match
);

    logic [7:0] acc_reg;

    // Clear wins over accumulate so a new session always starts from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg <= 8'h00;
        end else if (clr) begin
            acc_reg <= 8'h00;
        end else if (en) begin
            acc_reg <= acc_reg ^ din;
        end
    end

    assign acc   = acc_reg;
    assign match = (acc_reg == cmp_byte);

endmodule

// File: rtl/lock_key_loader.sv
// Collects the unlock key byte by byte, verifies the XOR checksum and commits
// the key atomically to the register that drives the locked core.
module lock_key_loader
    import lock_key_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_start,
    input  logic                 zeroize,
    lock_key_loader_if.slave     stream,
    output logic [KEY_W-1:0]     key_out,
    output logic                 key_loaded,
    output logic                 key_err,
    output logic                 busy
);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_LOAD  = LOAD;
    localparam logic [2:0] S_CHECK = CHECK;
    localparam logic [2:0] S_DONE  = DONE;
    localparam logic [2:0] S_ERR   = ERR;

    logic [2:0]       state_reg, state_next;
    logic [KEY_W-1:0] shadow_reg, key_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [7:0]       chk_reg;
    logic             key_loaded_reg, key_err_reg, busy_reg;

    logic             accept, start, body_byte, chk_match;
    logic [7:0]       acc_val;
    logic [IDX_W-1:0] byte_base;

    assign stream.s_ready = (state_reg == S_LOAD);
    // Zeroize must override a handshake landing on the same edge.
    assign accept    = stream.s_valid & stream.s_ready & ~zeroize;
    // A session can only (re)start from IDLE or after a failed check.
    assign start     = load_start & ~zeroize & ((state_reg == S_IDLE) || (state_reg == S_ERR));
    assign body_byte = accept & (cnt_reg < CNT_W'(NBYTES));
    assign byte_base = IDX_W'({cnt_reg, 3'b000});

    key_chk_acc u_chk_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (zeroize | start),
        .en       (body_byte),
        .din      (stream.s_data),
        .cmp_byte (chk_reg),
        .acc      (acc_val),
        .match    (chk_match)
    );

    // Next-state decode; zeroize returns to IDLE from anywhere.
    always_comb begin
        state_next = state_reg;
        if (zeroize) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:  if (start) state_next = S_LOAD;
                S_LOAD:  if (accept && !body_byte) state_next = S_CHECK;
                S_CHECK: state_next = chk_match ? S_DONE : S_ERR;
                S_DONE:  state_next = S_DONE;
                S_ERR:   if (start) state_next = S_LOAD;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // State, shadow capture, checksum latch and the atomic key commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            shadow_reg     <= '0;
            key_reg        <= '0;
            cnt_reg        <= '0;
            chk_reg        <= 8'h00;
            key_loaded_reg <= 1'b0;
            key_err_reg    <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == S_LOAD) || (state_next == S_CHECK);
            if (zeroize) begin
                shadow_reg     <= '0;
                key_reg        <= '0;
                cnt_reg        <= '0;
                chk_reg        <= 8'h00;
                key_loaded_reg <= 1'b0;
                key_err_reg    <= 1'b0;
            end else begin
                if (start) begin
                    shadow_reg  <= '0;
                    cnt_reg     <= '0;
                    key_err_reg <= 1'b0;
                end
                if (body_byte) begin
                    shadow_reg[byte_base +: 8] <= stream.s_data;
                    cnt_reg                    <= cnt_reg + 1'b1;
                end else if (accept) begin
                    chk_reg <= stream.s_data;
                end
                if (state_reg == S_CHECK) begin
                    if (chk_match) begin
                        key_reg        <= shadow_reg;
                        key_loaded_reg <= 1'b1;
                    end else begin
                        key_err_reg <= 1'b1;
                    end
                end
            end
        end
    end

    assign key_out    = key_reg;
    assign key_loaded = key_loaded_reg;
    assign key_err    = key_err_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_lock_key_loader.sv
// Directed bench for the key loader: good/bad checksums, lock, zeroize, gaps, reset.
module tb_lock_key_loader;
    import lock_key_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load_start = 1'b0;
    logic             zeroize = 1'b0;
    logic [KEY_W-1:0] key_out;
    logic             key_loaded, key_err, busy;

    int checks_cnt = 0;
    int errors_cnt = 0;

    // Key A: bytes 0x01..0x0D, XOR checksum 0x01.
    // Key B: bytes 0xF0..0xFC, XOR checksum 0xFC.
    localparam logic [KEY_W-1:0] KEY_A = 104'h0D_0C_0B_0A_09_08_07_06_05_04_03_02_01;
    localparam logic [KEY_W-1:0] KEY_B = 104'hFC_FB_FA_F9_F8_F7_F6_F5_F4_F3_F2_F1_F0;

    lock_key_loader_if bus ();

    lock_key_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .zeroize    (zeroize),
        .stream     (bus),
        .key_out    (key_out),
        .key_loaded (key_loaded),
        .key_err    (key_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic pulse_zeroize();
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got = 0;
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (bus.s_ready) begin
                got = 1;
                tick();
                break;
            end
            tick();
        end
        bus.s_valid = 1'b0;
        if (!got) check("handshake_timeout", 0, 1);
    endtask

    // Sends the 13 key bytes then the checksum; optional 3-cycle gap after byte gap_after.
    task automatic send_key(input logic [KEY_W-1:0] k, input logic [7:0] chk, input int gap_after);
        for (int i = 0; i < NBYTES; i++) begin
            send_byte(k[8*i +: 8]);
            if (i == gap_after) begin
                for (int g = 0; g < 3; g++) tick();
                check("gap_ready_held", bus.s_ready, 1);
                check("gap_busy_held", busy, 1);
            end
        end
        send_byte(chk);
    endtask

    initial begin
        bus.s_data  = 8'h00;
        bus.s_valid = 1'b0;

        // Reset then idle.
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("rst_key_out", key_out, 0);
        check("rst_key_loaded", key_loaded, 0);
        check("rst_key_err", key_err, 0);
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_busy", busy, 0);

        // s_valid in IDLE is ignored.
        bus.s_valid = 1'b1; bus.s_data = 8'hAA;
        tick(); tick();
        bus.s_valid = 1'b0;
        check("idle_valid_busy", busy, 0);

        // Good load of key A.
        pulse_start();
        check("start_ready", bus.s_ready, 1);
        check("start_busy", busy, 1);
        send_key(KEY_A, 8'h01, -1);
        check("chk_edge_loaded", key_loaded, 0);
        check("chk_edge_busy", busy, 1);
        check("chk_edge_ready", bus.s_ready, 0);
        tick();
        check("good_loaded", key_loaded, 1);
        check("good_key_lo", key_out[7:0], 8'h01);
        check("good_key_hi", key_out[103:96], 8'h0D);
        check("good_key_full", key_out, KEY_A);
        check("good_busy", busy, 0);
        check("good_err", key_err, 0);

        // Locked: load_start and 14 offered bytes are ignored.
        load_start = 1'b1;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            bus.s_data = 8'(8'h40 + i);
            tick();
            load_start = 1'b0;
            check("done_ready_low", bus.s_ready, 0);
        end
        bus.s_valid = 1'b0;
        check("done_key_held", key_out, KEY_A);
        check("done_loaded_held", key_loaded, 1);

        // Zeroize wipes the committed key.
        pulse_zeroize();
        check("zero_key_out", key_out, 0);
        check("zero_loaded", key_loaded, 0);

        // Bad checksum then retry.
        pulse_start();
        send_key(KEY_A, 8'h00, -1);
        tick();
        check("bad_err", key_err, 1);
        check("bad_key_out", key_out, 0);
        check("bad_loaded", key_loaded, 0);
        check("bad_busy", busy, 0);
        check("bad_ready", bus.s_ready, 0);
        pulse_start();
        check("retry_err_clear", key_err, 0);
        check("retry_ready", bus.s_ready, 1);
        send_key(KEY_A, 8'h01, -1);
        tick();
        check("retry_loaded", key_loaded, 1);
        check("retry_key", key_out, KEY_A);

        // Zeroize mid-LOAD after 6 bytes.
        pulse_zeroize();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(KEY_A[8*i +: 8]);
        pulse_zeroize();
        check("midz_ready", bus.s_ready, 0);
        check("midz_busy", busy, 0);
        check("midz_key_out", key_out, 0);

        // Zeroize together with load_start stays in IDLE.
        zeroize = 1'b1; load_start = 1'b1;
        tick();
        zeroize = 1'b0; load_start = 1'b0;
        check("zs_ready", bus.s_ready, 0);
        check("zs_busy", busy, 0);

        // Partial key discarded: fresh full load of key B with a gap after byte 4.
        pulse_start();
        send_key(KEY_B, 8'hFC, 3);
        tick();
        check("gap_loaded", key_loaded, 1);
        check("gap_key", key_out, KEY_B);

        // Reset after 10 bytes of a separate load.
        pulse_zeroize();
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(KEY_B[8*i +: 8]);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_key_out", key_out, 0);
        check("mrst_loaded", key_loaded, 0);
        check("mrst_err", key_err, 0);
        check("mrst_busy", busy, 0);
        check("mrst_ready", bus.s_ready, 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
